// File: rtl/mmt_sync_pkg.sv
// rtl/mmt_sync_pkg.sv - shared types and helpers for the req/ack sync controller
// Contents:
//   mmt_hs_state_e  handshake FSM state (IDLE, ASSERT, RELEASE)
//   timer_width()   width of a timer that must hold values 0..cycles (min 1)
package mmt_sync_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RELEASE = 2'd2
  } mmt_hs_state_e;

  function automatic int timer_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/mmt_sync_single.sv
// rtl/mmt_sync_single.sv - multi-flop level synchronizer for one bit
// Ports:
//   clk   in   destination clock
//   rstn  in   active-low reset (asynchronous when AsyncReset=1)
//   d     in   asynchronous level
//   q     out  d delayed by Depth clk edges
module mmt_sync_single #(
  parameter int Depth      = 2,
  parameter bit AsyncReset = 1'b1,
  parameter bit AsyncSet   = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  // AsyncSet selects the value the chain is forced to while in reset.
  localparam logic RstVal = AsyncSet;

  logic [Depth-1:0] sync_q;

  generate
    if (AsyncReset) begin : g_async
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) sync_q <= {Depth{RstVal}};
        else       sync_q <= {sync_q[Depth-2:0], d};
      end
    end else begin : g_sync
      always_ff @(posedge clk) begin
        if (!rstn) sync_q <= {Depth{RstVal}};
        else       sync_q <= {sync_q[Depth-2:0], d};
      end
    end
  endgenerate

  assign q = sync_q[Depth-1];

endmodule

// File: rtl/mmt_sync_req_ctrl.sv
// rtl/mmt_sync_req_ctrl.sv - source-side 4-phase req/ack event serialiser
// Ports:
//   clk        in   single clock
//   rstn       in   asynchronous active-low reset
//   push_i     in   one event per asserted cycle
//   clr_err_i  in   clears overflow_o and timeout_o
//   ack_i      in   async ack level from the far domain
//   req_o      out  registered req level
//   done_o     out  1-cycle pulse when a handshake completes
//   busy_o     out  handshake in flight or events queued
//   pending_o  out  queued events not yet started
//   overflow_o out  sticky: a push was dropped
//   timeout_o  out  sticky: a phase waited TimeoutCycles
module mmt_sync_req_ctrl
  import mmt_sync_pkg::*;
#(
  parameter int SyncDepth     = 3,
  parameter int CntWidth      = 4,
  parameter int TimeoutCycles = 64
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                push_i,
  input  logic                clr_err_i,
  input  logic                ack_i,
  output logic                req_o,
  output logic                done_o,
  output logic                busy_o,
  output logic [CntWidth-1:0] pending_o,
  output logic                overflow_o,
  output logic                timeout_o
);

  localparam int                TW        = timer_width(TimeoutCycles);
  localparam bit                TimeoutEn = (TimeoutCycles != 0);
  localparam logic [CntWidth-1:0] PMax    = {CntWidth{1'b1}};
  localparam logic [TW-1:0]     TLim      = TW'(TimeoutCycles);
  localparam logic [TW-1:0]     TPre      = TW'(TimeoutCycles - 1);

  mmt_hs_state_e       state, state_nxt;
  logic                ack_sync;
  logic [CntWidth-1:0] pending;
  logic [TW-1:0]       timer;
  logic                start, push_acc, drop, to_hit;
  logic                req_q, done_q, ovf_q, to_q;

  mmt_sync_single #(
    .Depth      (SyncDepth),
    .AsyncReset (1'b1),
    .AsyncSet   (1'b0)
  ) u_ack_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (ack_i),
    .q    (ack_sync)
  );

  // A push arriving while IDLE with nothing queued starts immediately, so a
  // full counter can still take a push in the cycle a start frees a slot.
  assign start    = (state == IDLE) && ((pending != '0) || push_i);
  assign push_acc = push_i && ((pending != PMax) || start);
  assign drop     = push_i && !push_acc;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = ASSERT;
      ASSERT:  if (ack_sync)  state_nxt = RELEASE;
      RELEASE: if (!ack_sync) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Fires only on the step onto the limit; the saturated timer cannot re-set
  // the flag after it has been cleared.
  assign to_hit = TimeoutEn && (state != IDLE) && (state_nxt == state) && (timer == TPre);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      pending <= '0;
      timer   <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= 1'b0;
      case (state)
        IDLE:    if (start)     req_q  <= 1'b1;
        ASSERT:  if (ack_sync)  req_q  <= 1'b0;
        RELEASE: if (!ack_sync) done_q <= 1'b1;
        default:                req_q  <= 1'b0;
      endcase

      if (push_acc && !start)      pending <= pending + CntWidth'(1);
      else if (!push_acc && start) pending <= pending - CntWidth'(1);

      if ((state_nxt != state) || (state == IDLE)) timer <= '0;
      else if (timer != TLim)                      timer <= timer + TW'(1);

      if (drop)           ovf_q <= 1'b1;
      else if (clr_err_i) ovf_q <= 1'b0;

      if (to_hit)         to_q  <= 1'b1;
      else if (clr_err_i) to_q  <= 1'b0;
    end
  end

  assign req_o      = req_q;
  assign done_o     = done_q;
  assign busy_o     = (state != IDLE) || (pending != '0);
  assign pending_o  = pending;
  assign overflow_o = ovf_q;
  assign timeout_o  = to_q;

endmodule

// File: tb/tb_mmt_sync_req_ctrl.sv
// tb/tb_mmt_sync_req_ctrl.sv - self-checking bench for mmt_sync_req_ctrl
module tb_mmt_sync_req_ctrl;

  localparam int SYNC_DEPTH = 3;
  localparam int CNT_W      = 4;
  localparam int TO_CYC     = 64;
  localparam int PMAX       = 15;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             push_i = 1'b0;
  logic             clr_err_i = 1'b0;
  logic             ack_i = 1'b0;
  logic             req_o, done_o, busy_o, overflow_o, timeout_o;
  logic [CNT_W-1:0] pending_o;

  mmt_sync_req_ctrl #(
    .SyncDepth     (SYNC_DEPTH),
    .CntWidth      (CNT_W),
    .TimeoutCycles (TO_CYC)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .push_i     (push_i),
    .clr_err_i  (clr_err_i),
    .ack_i      (ack_i),
    .req_o      (req_o),
    .done_o     (done_o),
    .busy_o     (busy_o),
    .pending_o  (pending_o),
    .overflow_o (overflow_o),
    .timeout_o  (timeout_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Scoreboard: each accepted push enqueues the handshake index it must become.
  int  exp_q[$];
  int  next_id = 0;

  // Monitor, sampling 1 time unit after each rising edge.
  int   cyc = 0, rise_cnt = 0, done_cnt = 0;
  int   ack_rise_cyc = 0, rise_cyc = 0, to_cyc = 0;
  logic req_prev = 1'b0, ack_prev = 1'b0, to_prev = 1'b0;
  bit   chk_lat = 1'b0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (!rstn) begin
      rise_cnt = 0;
      exp_q.delete();
    end else begin
      if (ack_i && !ack_prev) ack_rise_cyc = cyc;
      if (req_o && !req_prev) begin
        rise_cnt++;
        rise_cyc = cyc;
      end
      if (!req_o && req_prev && chk_lat)
        check("ack_to_req_fall", cyc - ack_rise_cyc, SYNC_DEPTH);
      if (timeout_o && !to_prev) to_cyc = cyc;
      if (done_o) begin
        done_cnt++;
        if (exp_q.size() == 0) check("done_unexpected", exp_q.size(), 1);
        else                   check("done_order", rise_cnt - 1, exp_q.pop_front());
      end
    end
    req_prev = req_o;
    ack_prev = ack_i;
    to_prev  = timeout_o;
  end

  // Far-side responder: mirrors req onto ack five cycles later when enabled.
  bit auto_ack = 1'b0;
  int rcnt = 0;

  always @(negedge clk) begin
    if (!auto_ack) begin
      rcnt  = 0;
      ack_i = 1'b0;
    end else if (req_o != ack_i) begin
      if (rcnt == 4) begin
        ack_i = req_o;
        rcnt  = 0;
      end else begin
        rcnt++;
      end
    end else begin
      rcnt = 0;
    end
  end

  typedef struct {
    bit push;
    bit acc;
    bit exp_req;
    int exp_pend;
    bit exp_ovf;
  } vec_t;

  vec_t vecs[21];

  task automatic check_vec(input int i);
    check($sformatf("vec%0d_req", i), req_o, vecs[i].exp_req);
    check($sformatf("vec%0d_pending", i), pending_o, vecs[i].exp_pend);
    check($sformatf("vec%0d_overflow", i), overflow_o, vecs[i].exp_ovf);
  endtask

  task automatic apply_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      if (i > lo) check_vec(i - 1);
      push_i = vecs[i].push;
      if (vecs[i].push && vecs[i].acc) begin
        exp_q.push_back(next_id);
        next_id++;
      end
    end
    @(negedge clk);
    push_i = 1'b0;
    check_vec(hi);
  endtask

  task automatic push_once();
    @(negedge clk);
    push_i = 1'b1;
    exp_q.push_back(next_id);
    next_id++;
    @(negedge clk);
    push_i = 1'b0;
  endtask

  task automatic wait_dones(input string name, input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) @(negedge clk);
    check(name, done_cnt, target);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_err_i = 1'b1;
    @(negedge clk);
    clr_err_i = 1'b0;
  endtask

  int d0;

  initial begin
    // Scenario 2 (three consecutive pushes, ack held low)
    vecs[0] = '{1'b1, 1'b1, 1'b1, 0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 2, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 2, 1'b0};
    // Scenario 3 (17 pushes, ack held low: one starts, 15 queue, last dropped)
    for (int i = 0; i < 17; i++)
      vecs[4 + i] = '{1'b1, (i < 16), 1'b1, (i > PMAX) ? PMAX : i, (i == 16)};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req", req_o, 0);
    check("rst_done", done_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_pending", pending_o, 0);
    check("rst_overflow", overflow_o, 0);
    check("rst_timeout", timeout_o, 0);
    rstn = 1'b1;

    // 1: single push, minimum latency and sync depth of the ack path
    auto_ack = 1'b1;
    chk_lat  = 1'b1;
    d0 = done_cnt;
    push_once();
    check("s1_req_n1", req_o, 1);
    check("s1_busy", busy_o, 1);
    wait_dones("s1_done_wait", d0 + 1, 200);
    repeat (5) @(negedge clk);
    check("s1_done_count", done_cnt - d0, 1);
    check("s1_busy_after", busy_o, 0);
    check("s1_req_after", req_o, 0);
    chk_lat = 1'b0;

    // 2: three back-to-back pushes
    auto_ack = 1'b0;
    d0 = done_cnt;
    apply_vecs(0, 3);
    auto_ack = 1'b1;
    wait_dones("s2_done_wait", d0 + 3, 400);
    repeat (3) @(negedge clk);
    check("s2_done_count", done_cnt - d0, 3);
    check("s2_overflow", overflow_o, 0);
    check("s2_busy_after", busy_o, 0);

    // 3: overflow with ack held low, then drain 16 handshakes
    auto_ack = 1'b0;
    d0 = done_cnt;
    apply_vecs(4, 20);
    auto_ack = 1'b1;
    wait_dones("s3_done_wait", d0 + 16, 1200);
    repeat (5) @(negedge clk);
    check("s3_done_count", done_cnt - d0, 16);
    check("s3_busy_after", busy_o, 0);
    check("s3_overflow_sticky", overflow_o, 1);
    pulse_clr();
    check("s3_overflow_clr", overflow_o, 0);

    // 6: push while IDLE with pending full is accepted without overflow
    auto_ack = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    push_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(next_id);
      next_id++;
      @(negedge clk);
    end
    push_i = 1'b0;
    check("s6_pending_full", pending_o, PMAX);
    auto_ack = 1'b1;
    for (int i = 0; i < 300 && !done_o; i++) @(negedge clk);
    check("s6_done_seen", done_o, 1);
    check("s6_pending_idle", pending_o, PMAX);
    push_i = 1'b1;
    exp_q.push_back(next_id);
    next_id++;
    @(negedge clk);
    push_i = 1'b0;
    check("s6_pending_kept", pending_o, PMAX);
    check("s6_overflow", overflow_o, 0);
    wait_dones("s6_done_wait", d0 + 17, 1400);
    repeat (3) @(negedge clk);
    check("s6_done_count", done_cnt - d0, 17);
    check("s6_overflow_end", overflow_o, 0);

    // 4: timeout after 64 cycles in ASSERT, clear, late ack completes
    auto_ack = 1'b0;
    d0 = done_cnt;
    push_once();
    check("s4_req", req_o, 1);
    for (int i = 0; i < 100 && !timeout_o; i++) @(negedge clk);
    check("s4_timeout_set", timeout_o, 1);
    check("s4_timeout_lat", to_cyc - rise_cyc, TO_CYC);
    check("s4_req_held", req_o, 1);
    pulse_clr();
    check("s4_timeout_clr", timeout_o, 0);
    repeat (3) @(negedge clk);
    check("s4_timeout_stays_clr", timeout_o, 0);
    auto_ack = 1'b1;
    wait_dones("s4_late_done", d0 + 1, 200);
    repeat (3) @(negedge clk);
    check("s4_busy_after", busy_o, 0);

    // 5: asynchronous reset mid-ASSERT with three events queued
    auto_ack = 1'b0;
    @(negedge clk);
    push_i = 1'b1;
    repeat (4) @(negedge clk);
    push_i = 1'b0;
    check("s5_pending_pre", pending_o, 3);
    check("s5_req_pre", req_o, 1);
    #2 rstn = 1'b0;
    #1;
    check("s5_rst_req", req_o, 0);
    check("s5_rst_pending", pending_o, 0);
    check("s5_rst_busy", busy_o, 0);
    check("s5_rst_overflow", overflow_o, 0);
    check("s5_rst_timeout", timeout_o, 0);
    d0 = done_cnt;
    next_id = 0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    check("s5_no_done", done_cnt - d0, 0);
    auto_ack = 1'b1;
    push_once();
    check("s5_req_after", req_o, 1);
    wait_dones("s5_done_wait", d0 + 1, 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
